fifo_spi_tx: RTL

//  Downstream drain stage of the FIFO. Pops words when the FIFO is non-empty and

---
 rtl/fifo_spi_tx_pkg.sv | 32 +++
 rtl/fifo_spi_tx_if.sv | 41 ++++
 rtl/fifo_spi_tx_sck_tick_gen.sv | 49 ++++
 rtl/fifo_spi_tx.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/fifo_spi_tx_pkg.sv
// -----------------------------------------------------------------------------
// fifo_spi_pkg
//   Shared types and sizing helpers for the FIFO -> SPI drain stage.
//   state_e   : drain FSM states, IDLE -> FETCH -> LOAD -> SHIFT -> GAP.
//   div_w     : width of the sclk half-period divider ($clog2(CLK_DIV), min 1).
//   bit_cnt_w : width of the per-word bit counter ($clog2(DATA_WIDTH+1)).
//   gap_w     : width of the cs_n inter-word gap counter (min 1).
// -----------------------------------------------------------------------------
package fifo_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SHIFT,
        GAP
    } state_e;

    // A divide-by-1 still needs a one-bit counter so the port widths stay legal.
    function automatic int div_w(input int clk_div);
        return (clk_div > 1) ? $clog2(clk_div) : 1;
    endfunction

    function automatic int bit_cnt_w(input int data_width);
        return $clog2(data_width + 1);
    endfunction

    function automatic int gap_w(input int cs_gap);
        return (cs_gap > 1) ? $clog2(cs_gap) : 1;
    endfunction

endpackage

// File: rtl/fifo_spi_tx_if.sv
// -----------------------------------------------------------------------------
// fifo_spi_tx_if
//   Bundles the FIFO read port and the SPI pins seen by the drain stage.
//   fifo_empty    : FIFO empty flag                      (FIFO -> drain)
//   fifo_data_out : FIFO read data, valid cycle after rd (FIFO -> drain)
//   fifo_rd_en    : one-cycle read strobe per word       (drain -> FIFO)
//   sclk/mosi/cs_n: SPI mode-0 master outputs            (drain -> slave)
//   miso          : SPI serial data from the slave       (slave -> drain)
//   master modport: the drain stage; slave modport: the FIFO/SPI-slave side.
// -----------------------------------------------------------------------------
interface fifo_spi_tx_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data_out;
    logic                  fifo_rd_en;
    logic                  sclk;
    logic                  mosi;
    logic                  miso;
    logic                  cs_n;

    modport master (
        input  fifo_empty,
        input  fifo_data_out,
        input  miso,
        output fifo_rd_en,
        output sclk,
        output mosi,
        output cs_n
    );

    modport slave (
        output fifo_empty,
        output fifo_data_out,
        output miso,
        input  fifo_rd_en,
        input  sclk,
        input  mosi,
        input  cs_n
    );
endinterface

// File: rtl/fifo_spi_tx_sck_tick_gen.sv
// -----------------------------------------------------------------------------
// sck_tick_gen
//   Divides clk into sclk half-periods of CLK_DIV cycles and flags which edge
//   the next sclk transition is. The first half-period after clear ends in a
//   rise, the next in a fall, alternating.
//   clk       in  : system clock
//   rst       in  : synchronous active-high reset
//   clear     in  : restart the divider and phase (pulsed while loading a word)
//   run       in  : count only while shifting
//   rise_tick out : last cycle of a low half-period, sclk should go high
//   fall_tick out : last cycle of a high half-period, sclk should go low
// -----------------------------------------------------------------------------
module sck_tick_gen
    import fifo_spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic rise_tick,
    output logic fall_tick
);
    localparam int             DIVW     = div_w(CLK_DIV);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);

    logic [DIVW-1:0] div_cnt;
    logic            phase;     // 0: sclk currently low, 1: sclk currently high
    logic            half_done;

    assign half_done = run && (div_cnt == DIV_LAST);
    assign rise_tick = half_done && !phase;
    assign fall_tick = half_done &&  phase;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            div_cnt <= '0;
            phase   <= 1'b0;
        end else if (run) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                phase   <= ~phase;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/fifo_spi_tx.sv
// -----------------------------------------------------------------------------
// fifo_spi_tx
//   Drain stage of the FIFO: pops one word whenever the FIFO is non-empty and
//   enable is high, then shifts it out MSB-first on an SPI mode-0 master link
//   while capturing miso into a parallel word.
//   clk        in  : system clock, rising edge
//   rst        in  : synchronous active-high reset (aborts any word in flight)
//   enable     in  : permits new words to start; a running word always finishes
//   bus        if  : FIFO read port + SPI pins (master modport)
//   busy       out : high whenever the FSM is outside IDLE
//   rx_data    out : word captured from miso during the last transfer
//   rx_valid   out : one-cycle pulse when rx_data updates (same cycle cs_n rises)
//   words_sent out : completed-word counter, wraps silently at 2^16
//   Word period = 2*CLK_DIV*DATA_WIDTH + CS_GAP + 3 clk cycles.
// -----------------------------------------------------------------------------
module fifo_spi_tx
    import fifo_spi_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CLK_DIV    = 2,
    parameter int CS_GAP     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    fifo_spi_tx_if.master         bus,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic [15:0]           words_sent
);
    localparam int              BCW      = bit_cnt_w(DATA_WIDTH);
    localparam logic [BCW-1:0]  BIT_LAST = BCW'(DATA_WIDTH - 1);
    localparam int              GW       = gap_w(CS_GAP);
    localparam logic [GW-1:0]   GAP_LAST = GW'(CS_GAP - 1);

    state_e state, next_state;

    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] rxreg;
    logic [BCW-1:0]        bit_cnt;
    logic [GW-1:0]         gap_cnt;

    logic rd_en_q, sclk_q, mosi_q, cs_n_q;
    logic rise_tick, fall_tick, last_fall;

    assign bus.fifo_rd_en = rd_en_q;
    assign bus.sclk       = sclk_q;
    assign bus.mosi       = mosi_q;
    assign bus.cs_n       = cs_n_q;

    // Divider restarts on every word so each SHIFT begins with a full low
    // half-period and lasts exactly 2*CLK_DIV*DATA_WIDTH cycles.
    sck_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk       (clk),
        .rst       (rst),
        .clear     (state == LOAD),
        .run       (state == SHIFT),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    assign last_fall = fall_tick && (bit_cnt == BIT_LAST);

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // ---------------- FSM next state ----------------
    // fifo_empty only matters in IDLE; once a word is fetched it runs to GAP.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (enable && !bus.fifo_empty) next_state = FETCH;
            FETCH:   next_state = LOAD;
            LOAD:    next_state = SHIFT;
            SHIFT:   if (last_fall) next_state = GAP;
            GAP:     if (gap_cnt == GAP_LAST) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // ---------------- registered outputs and datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en_q    <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            busy       <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            words_sent <= '0;
            shreg      <= '0;
            rxreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
        end else begin
            // Registered from next_state so these line up with the state itself.
            rd_en_q  <= (next_state == FETCH);
            busy     <= (next_state != IDLE);
            rx_valid <= 1'b0;
            gap_cnt  <= (state == GAP) ? gap_cnt + 1'b1 : '0;

            case (state)
                LOAD: begin
                    // MSB goes straight to mosi; shreg holds the remaining bits
                    // already aligned so shreg's MSB is always the next bit out.
                    mosi_q  <= bus.fifo_data_out[DATA_WIDTH-1];
                    shreg   <= {bus.fifo_data_out[DATA_WIDTH-2:0], 1'b0};
                    cs_n_q  <= 1'b0;
                    bit_cnt <= '0;
                end
                SHIFT: begin
                    if (rise_tick) begin
                        sclk_q <= 1'b1;
                        rxreg  <= {rxreg[DATA_WIDTH-2:0], bus.miso};
                    end
                    if (fall_tick) begin
                        sclk_q <= 1'b0;
                        if (last_fall) begin
                            // Word complete: mosi is left alone on this fall.
                            rx_data    <= rxreg;
                            rx_valid   <= 1'b1;
                            words_sent <= words_sent + 16'd1;
                            cs_n_q     <= 1'b1;
                        end else begin
                            mosi_q  <= shreg[DATA_WIDTH-1];
                            shreg   <= {shreg[DATA_WIDTH-2:0], 1'b0};
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
